i2s_rx_capture: RTL and testbench

//  Receives the debug I2S serial stream (bclk, lrck, sdata) in the system clock domain.

---
 rtl/i2s_rx_capture.sv | 214 +++++++++++++++++++++
 tb/tb_i2s_rx_capture.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_capture.sv
// I2S receiver: syncs bclk/lrck/sdata, deserializes slots, AXI-stream out.
// Optional sine-table pattern checker behind I2S_RX_PATTERN_CHECK_EN.
module i2s_rx_capture #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i2s_bclk,
  input  logic                  i2s_lrck,
  input  logic                  i2s_sdata,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  overflow,
  output logic                  frame_err,
  output logic                  chk_locked,
  output logic [15:0]           chk_err_count
);

  localparam int CW = $clog2(DATA_WIDTH + 2);

  logic [SYNC_STAGES-1:0] bclk_sq, lrck_sq, sdat_sq;
  logic                   bclk_s, lrck_s, sdat_s;
  logic                   rise, bnd, acc, word_ok;

  logic                  bclk_prev_q;
  logic                  lrck_prev_q, lrck_prev_d;
  logic                  prev_vld_q, prev_vld_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  first_q, first_d;
  logic                  bnd_q, bnd_ok_q, bnd_ok_d;
  logic                  bnd_ch_q;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tuser_q, tuser_d;
  logic                  tvalid_q, tvalid_d;
  logic                  ovf_q, ovf_d;
  logic                  ferr_q, ferr_d;

  assign bclk_s = bclk_sq[SYNC_STAGES-1];
  assign lrck_s = lrck_sq[SYNC_STAGES-1];
  assign sdat_s = sdat_sq[SYNC_STAGES-1];

  // lrck_prev is only trusted once a bclk rise has been seen since reset
  assign rise = bclk_s & ~bclk_prev_q;
  assign bnd  = rise & prev_vld_q & (lrck_s != lrck_prev_q);
  assign acc  = tvalid_q & m_axis_tready;
  assign word_ok = bnd_q & ~first_q & bnd_ok_q;

  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    lrck_prev_d = lrck_prev_q;
    prev_vld_d  = prev_vld_q;
    bnd_ok_d    = (cnt_q == CW'(DATA_WIDTH - 1));
    if (rise) begin
      shift_d     = {shift_q[DATA_WIDTH-2:0], sdat_s};
      lrck_prev_d = lrck_s;
      prev_vld_d  = 1'b1;
      if (cnt_q != CW'(DATA_WIDTH + 1))
        cnt_d = cnt_q + CW'(1);
      if (bnd)
        cnt_d = '0;
    end
  end

  always_comb begin
    first_d  = first_q;
    tvalid_d = tvalid_q & ~acc;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    ovf_d    = 1'b0;
    ferr_d   = 1'b0;
    if (bnd_q) begin
      if (first_q) begin
        first_d = 1'b0;
      end else if (!bnd_ok_q) begin
        ferr_d = 1'b1;
      end else if (!tvalid_q || m_axis_tready) begin
        tdata_d  = shift_q;
        tuser_d  = bnd_ch_q;
        tvalid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bclk_sq     <= '0;
      lrck_sq     <= '0;
      sdat_sq     <= '0;
      bclk_prev_q <= 1'b0;
      lrck_prev_q <= 1'b0;
      prev_vld_q  <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b1;
      bnd_q       <= 1'b0;
      bnd_ok_q    <= 1'b0;
      bnd_ch_q    <= 1'b0;
      tdata_q     <= '0;
      tuser_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      ovf_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      bclk_sq     <= {bclk_sq[SYNC_STAGES-2:0], i2s_bclk};
      lrck_sq     <= {lrck_sq[SYNC_STAGES-2:0], i2s_lrck};
      sdat_sq     <= {sdat_sq[SYNC_STAGES-2:0], i2s_sdata};
      bclk_prev_q <= bclk_s;
      lrck_prev_q <= lrck_prev_d;
      prev_vld_q  <= prev_vld_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      bnd_q       <= bnd;
      bnd_ok_q    <= bnd_ok_d;
      bnd_ch_q    <= lrck_prev_q;
      tdata_q     <= tdata_d;
      tuser_q     <= tuser_d;
      tvalid_q    <= tvalid_d;
      ovf_q       <= ovf_d;
      ferr_q      <= ferr_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign overflow      = ovf_q;
  assign frame_err     = ferr_q;

`ifdef I2S_RX_PATTERN_CHECK_EN
  if (DATA_WIDTH != 32) begin : g_dw_err
    $error("i2s_rx_capture: pattern checker needs DATA_WIDTH == 32");
  end

  function automatic logic [31:0] sine(input logic [3:0] i);
    logic [31:0] v;
    v = '0;
    unique case (i)
      4'd0:  v = 32'h00000000;
      4'd1:  v = 32'h30FBC550;
      4'd2:  v = 32'h5A8279A0;
      4'd3:  v = 32'h7641AF40;
      4'd4:  v = 32'h7FFFFFFF;
      4'd5:  v = 32'h7641AF40;
      4'd6:  v = 32'h5A8279A0;
      4'd7:  v = 32'h30FBC550;
      4'd8:  v = 32'h00000000;
      4'd9:  v = 32'hCF043AB0;
      4'd10: v = 32'hA57D8660;
      4'd11: v = 32'h89BE50C0;
      4'd12: v = 32'h80000000;
      4'd13: v = 32'h89BE50C0;
      4'd14: v = 32'hA57D8660;
      4'd15: v = 32'hCF043AB0;
    endcase
    return v;
  endfunction

  logic [31:0] cw;
  logic        lock_q, lock_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] err_q, err_d;

  assign cw = 32'(shift_q);

  // a mismatching word is retested so a fresh peak relocks immediately
  always_comb begin
    lock_d = lock_q;
    idx_d  = idx_q;
    err_d  = err_q;
    if (word_ok) begin
      if (lock_q && cw == sine(idx_q)) begin
        idx_d = idx_q + 4'd1;
      end else begin
        if (lock_q) begin
          lock_d = 1'b0;
          if (err_q != 16'hFFFF)
            err_d = err_q + 16'd1;
        end
        if (cw == 32'h7FFFFFFF) begin
          lock_d = 1'b1;
          idx_d  = 4'd5;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
      idx_q  <= '0;
      err_q  <= '0;
    end else begin
      lock_q <= lock_d;
      idx_q  <= idx_d;
      err_q  <= err_d;
    end
  end

  assign chk_locked    = lock_q;
  assign chk_err_count = err_q;
`else
  assign chk_locked    = 1'b0;
  assign chk_err_count = '0;
`endif

endmodule

// File: tb/tb_i2s_rx_capture.sv
// Bench for i2s_rx_capture: slot-level I2S driver, word scoreboard,
// pulse counters and a reference pattern-checker model.
module tb_i2s_rx_capture;

  localparam int W    = 32;
  localparam int SS   = 2;
  localparam int HALF = 40;
`ifdef I2S_RX_PATTERN_CHECK_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic         clk = 0, rst_n = 0;
  logic         bclk = 0, lrck = 0, sdata = 0;
  logic         tready = 0;
  logic [W-1:0] tdata;
  logic         tuser, tvalid, ovf, ferr, locked;
  logic [15:0]  errc;

  i2s_rx_capture #(.DATA_WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n),
    .i2s_bclk(bclk), .i2s_lrck(lrck), .i2s_sdata(sdata),
    .m_axis_tdata(tdata), .m_axis_tuser(tuser),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .overflow(ovf), .frame_err(ferr),
    .chk_locked(locked), .chk_err_count(errc)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [31:0] sine [16] = '{
    32'h00000000, 32'h30FBC550, 32'h5A8279A0, 32'h7641AF40,
    32'h7FFFFFFF, 32'h7641AF40, 32'h5A8279A0, 32'h30FBC550,
    32'h00000000, 32'hCF043AB0, 32'hA57D8660, 32'h89BE50C0,
    32'h80000000, 32'h89BE50C0, 32'hA57D8660, 32'hCF043AB0};

  logic [32:0] expq[$];
  int   exp_ferr = 0, exp_ovf = 0, seen_ferr = 0, seen_ovf = 0;
  bit   m_first = 1, blocked = 0, occ = 0;
  bit   pend_v = 0, pend_ch = 0;
  logic [63:0] pend_w = '0;
  int   pend_n = 0;
  bit   m_lock = 0;
  int   m_idx = 0, m_err = 0;
  bit   ch_next = 0, prevd = 0;
  bit   rnd_ready = 0, force_ready = 1, lat_go = 0;

  function automatic logic exp_lock();
    return CHK_ON ? m_lock : 1'b0;
  endfunction

  function automatic logic [15:0] exp_err();
    return CHK_ON ? 16'(m_err) : 16'h0;
  endfunction

  task automatic pat_model(input logic [31:0] w);
    if (m_lock && w == sine[m_idx]) begin
      m_idx = (m_idx + 1) % 16;
    end else begin
      if (m_lock) begin
        m_lock = 0;
        if (m_err < 65535) m_err++;
      end
      if (w == 32'h7FFFFFFF) begin
        m_lock = 1;
        m_idx  = 5;
      end
    end
  endtask

  // the pending slot ends at the lrck edge that opens the next one
  task automatic complete_pending();
    if (!pend_v) return;
    if (m_first) begin
      m_first = 0;
    end else if (pend_n != W) begin
      exp_ferr++;
    end else begin
      pat_model(pend_w[31:0]);
      if (blocked && occ) exp_ovf++;
      else begin
        expq.push_back({pend_ch, pend_w[31:0]});
        if (blocked) occ = 1;
      end
    end
  endtask

  task automatic model_reset();
    expq.delete();
    m_first = 1;
    occ     = 0;
    m_lock  = 0;
    m_idx   = 0;
    m_err   = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_locked", locked, 0);
    chk("rst_errc", errc, 0);
  endtask

  task automatic send(input logic [63:0] w, input int n,
                      input int rst_at, input bit lat);
    complete_pending();
    pend_v  = 1;
    pend_ch = ch_next;
    pend_w  = w;
    pend_n  = n;
    for (int j = 0; j < n; j++) begin
      bclk  = 0;
      lrck  = ch_next;
      sdata = prevd;
      if (j == rst_at) begin
        rst_n = 0;
        #27;
        check_reset_outputs();
        #3;
        rst_n = 1;
        model_reset();
        #(HALF - 30);
      end else begin
        #HALF;
      end
      if (j == 0 && lat) lat_go = 1;
      bclk = 1;
      #HALF;
      prevd = w[n-1-j];
    end
    ch_next = ~ch_next;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000 && expq.size() != 0; i++)
      @(negedge clk);
    chk("drain", expq.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    tready = rnd_ready ? 1'($urandom_range(0, 1)) : force_ready;
  end

  logic        hv = 0;
  logic [32:0] hd = '0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      hv = 0;
      continue;
    end
    if (ferr) seen_ferr++;
    if (ovf) seen_ovf++;
    if (hv && tvalid) chk("hold", {tuser, tdata}, hd);
    hv = tvalid && !tready;
    hd = {tuser, tdata};
    if (tvalid && tready) begin
      if (expq.size() == 0) chk("unexp_word", expq.size(), 1);
      else chk("word", {tuser, tdata}, expq.pop_front());
    end
  end

  initial forever begin
    int  n;
    bit  seen;
    @(posedge bclk);
    if (lat_go) begin
      lat_go = 0;
      n = 0;
      seen = 0;
      for (int k = 0; k < 12 && !seen; k++) begin
        @(posedge clk);
        n++;
        #1;
        if (tvalid) seen = 1;
      end
      chk("latency", n, SS + 2);
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: total=%0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    rst_n = 0;
    #40;
    check_reset_outputs();
    rst_n = 1;

    // alternating fixed words, sink always ready
    for (int i = 0; i < 6; i++)
      send(i[0] ? 64'h5A5A5A5B : 64'hA5A5A5A5, W, -1, i == 2);
    wait_drain();
    chk("t1_ferr", seen_ferr, exp_ferr);
    chk("t1_ovf", seen_ovf, exp_ovf);

    // stalled sink across two completed words
    force_ready = 0;
    blocked = 1;
    occ = 0;
    send(64'h11223344, W, -1, 0);
    send(64'h55667788, W, -1, 0);
    #3000;
    chk("t2_held_valid", tvalid, 1);
    chk("t2_ovf", seen_ovf, exp_ovf);
    blocked = 0;
    occ = 0;
    force_ready = 1;
    wait_drain();
    chk("t2_ovf_final", seen_ovf, exp_ovf);

    // short slot then normal slots
    send(64'h0BADF00D, 31, -1, 0);
    for (int i = 0; i < 3; i++)
      send(64'(32'hC0DE0000 + i), W, -1, 0);
    wait_drain();
    chk("t3_ferr", seen_ferr, exp_ferr);

    // reset in the middle of a slot
    send(64'h12345678, W, 10, 0);
    for (int i = 0; i < 3; i++)
      send(64'(32'hBEEF0000 + i), W, -1, 0);
    wait_drain();
    chk("t4_ferr", seen_ferr, exp_ferr);
    chk("t4_ovf", seen_ovf, exp_ovf);

    // random words, random slot lengths, random back-pressure
    rnd_ready = 1;
    for (int i = 0; i < 60; i++) begin
      logic [63:0] w;
      int n;
      w = {$urandom, $urandom};
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(28, 40) : W;
      send(w, n, -1, 0);
    end
    rnd_ready = 0;
    force_ready = 1;
    wait_drain();
    chk("rnd_ferr", seen_ferr, exp_ferr);
    chk("rnd_ovf", seen_ovf, exp_ovf);

    // sine table, then one corrupted sample, then relock
    for (int i = 0; i < 64; i++)
      send({32'h0, sine[i%16]}, W, -1, 0);
    send({32'h0, sine[0]}, W, -1, 0);
    #200;
    chk("pat_lock", locked, exp_lock());
    chk("pat_err0", errc, exp_err());
    for (int i = 1; i < 5; i++)
      send({32'h0, sine[i]}, W, -1, 0);
    send(64'h7641AF41, W, -1, 0);
    send({32'h0, sine[6]}, W, -1, 0);
    #200;
    chk("pat_unlock", locked, exp_lock());
    chk("pat_err1", errc, exp_err());
    for (int i = 7; i < 21; i++)
      send({32'h0, sine[i%16]}, W, -1, 0);
    send({32'h0, sine[5]}, W, -1, 0);
    #200;
    chk("pat_relock", locked, exp_lock());
    chk("pat_err_keep", errc, exp_err());
    wait_drain();
    chk("end_ferr", seen_ferr, exp_ferr);
    chk("end_ovf", seen_ovf, exp_ovf);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
